// File: rtl/i2c_slave_regfile.sv
// AT24C02-style I2C slave emulating a 256x8 EEPROM, with debug read port and status outputs.
// Optional write-protect input enabled by defining I2C_SLAVE_WP_EN.
//
// state      | meaning
// IDLE       | bus free, waiting for START
// DEV_ADDR   | shifting in device address + R/W
// DEV_ACK_W  | ACK of address byte (write)
// REG_ADDR   | shifting in word address
// REG_ACK    | ACK of word address
// WR_DATA    | shifting in data byte, commit on 8th bit
// WR_ACK     | ACK (or NACK when protected) of data byte
// DEV_ACK_R  | ACK of address byte (read), first byte loaded at its end
// RD_DATA    | driving data byte MSB first
// RD_ACK     | sampling master ACK/NACK
// IGNORE     | not addressed / read finished, wait for START or STOP
module i2c_slave_regfile #(
  parameter logic [6:0] DEV_ADDR   = 7'h50,
  parameter int         DEPTH_LOG2 = 8,
  parameter logic [7:0] INIT_VAL   = 8'h00
) (
  input  logic       clk_12m,
  input  logic       rst_n,
  input  logic       scl,
  inout  wire        sda,
`ifdef I2C_SLAVE_WP_EN
  input  logic       wp,
`endif
  input  logic [7:0] dbg_addr,
  output logic [7:0] dbg_data,
  output logic       wr_strobe,
  output logic [7:0] last_wr_data,
  output logic [7:0] word_ptr,
  output logic [7:0] state_debug,
  output logic       busy
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_DEV_ADDR  = 4'd1,
    ST_DEV_ACK_W = 4'd2,
    ST_REG_ADDR  = 4'd3,
    ST_REG_ACK   = 4'd4,
    ST_WR_DATA   = 4'd5,
    ST_WR_ACK    = 4'd6,
    ST_DEV_ACK_R = 4'd7,
    ST_RD_DATA   = 4'd8,
    ST_RD_ACK    = 4'd9,
    ST_IGNORE    = 4'd10
  } state_t;

  logic scl_s1_q, scl_s2_q, scl_p_q;
  logic sda_s1_q, sda_s2_q, sda_p_q;
  logic wp_on;

  state_t                state_q, state_d;
  logic [3:0]            bit_cnt_q, bit_cnt_d;
  logic [7:0]            shift_q, shift_d;
  logic [7:0]            tx_q, tx_d;
  logic [DEPTH_LOG2-1:0] ptr_q, ptr_d;
  logic                  sda_low_q, sda_low_d;
  logic                  ack_phase_q, ack_phase_d;
  logic                  ack_ok_q, ack_ok_d;
  logic                  load_pend_q, load_pend_d;
  logic                  busy_q, busy_d;
  logic                  wr_strobe_q, wr_strobe_d;
  logic [7:0]            last_wr_data_q, last_wr_data_d;
  logic [7:0]            mem_q [DEPTH];
  logic                  mem_we;

  logic       scl_rise, scl_fall, start_det, stop_det;
  logic [7:0] shift_in, rd_byte;

`ifdef I2C_SLAVE_WP_EN
  logic wp_s1_q, wp_s2_q;
  always_ff @(posedge clk_12m or negedge rst_n) begin
    if (!rst_n) begin
      wp_s1_q <= 1'b0;
      wp_s2_q <= 1'b0;
    end else begin
      wp_s1_q <= wp;
      wp_s2_q <= wp_s1_q;
    end
  end
  assign wp_on = wp_s2_q;
`else
  assign wp_on = 1'b0;
`endif

  // Synchronizers reset high (idle bus) so no phantom START/STOP follows reset.
  always_ff @(posedge clk_12m or negedge rst_n) begin
    if (!rst_n) begin
      scl_s1_q <= 1'b1;
      scl_s2_q <= 1'b1;
      scl_p_q  <= 1'b1;
      sda_s1_q <= 1'b1;
      sda_s2_q <= 1'b1;
      sda_p_q  <= 1'b1;
    end else begin
      scl_s1_q <= scl;
      scl_s2_q <= scl_s1_q;
      scl_p_q  <= scl_s2_q;
      sda_s1_q <= sda;
      sda_s2_q <= sda_s1_q;
      sda_p_q  <= sda_s2_q;
    end
  end

  assign scl_rise  = scl_s2_q & ~scl_p_q;
  assign scl_fall  = ~scl_s2_q & scl_p_q;
  assign start_det = scl_s2_q & sda_p_q & ~sda_s2_q;
  assign stop_det  = scl_s2_q & ~sda_p_q & sda_s2_q;
  assign shift_in  = {shift_q[6:0], sda_s2_q};
  assign rd_byte   = mem_q[ptr_q];

  // State register
  always_ff @(posedge clk_12m or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      bit_cnt_q      <= 4'd0;
      shift_q        <= 8'd0;
      tx_q           <= 8'd0;
      ptr_q          <= '0;
      sda_low_q      <= 1'b0;
      ack_phase_q    <= 1'b0;
      ack_ok_q       <= 1'b0;
      load_pend_q    <= 1'b0;
      busy_q         <= 1'b0;
      wr_strobe_q    <= 1'b0;
      last_wr_data_q <= 8'd0;
    end else begin
      state_q        <= state_d;
      bit_cnt_q      <= bit_cnt_d;
      shift_q        <= shift_d;
      tx_q           <= tx_d;
      ptr_q          <= ptr_d;
      sda_low_q      <= sda_low_d;
      ack_phase_q    <= ack_phase_d;
      ack_ok_q       <= ack_ok_d;
      load_pend_q    <= load_pend_d;
      busy_q         <= busy_d;
      wr_strobe_q    <= wr_strobe_d;
      last_wr_data_q <= last_wr_data_d;
    end
  end

  always_ff @(posedge clk_12m or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= INIT_VAL;
    end else if (mem_we) begin
      mem_q[ptr_q] <= shift_in;
    end
  end

  // Next-state and datapath; bus conditions override all bit-level activity.
  always_comb begin
    state_d        = state_q;
    bit_cnt_d      = bit_cnt_q;
    shift_d        = shift_q;
    tx_d           = tx_q;
    ptr_d          = ptr_q;
    sda_low_d      = sda_low_q;
    ack_phase_d    = ack_phase_q;
    ack_ok_d       = ack_ok_q;
    load_pend_d    = load_pend_q;
    busy_d         = busy_q;
    wr_strobe_d    = 1'b0;
    last_wr_data_d = last_wr_data_q;
    mem_we         = 1'b0;

    if (start_det || stop_det) begin
      state_d     = start_det ? ST_DEV_ADDR : ST_IDLE;
      bit_cnt_d   = 4'd0;
      sda_low_d   = 1'b0;
      ack_phase_d = 1'b0;
      load_pend_d = 1'b0;
      busy_d      = 1'b0;
    end else begin
      case (state_q)
        ST_DEV_ADDR, ST_REG_ADDR, ST_WR_DATA: begin
          if (scl_rise) begin
            shift_d   = shift_in;
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) begin
              bit_cnt_d = 4'd0;
              ack_ok_d  = 1'b1;
              case (state_q)
                ST_DEV_ADDR: begin
                  if (shift_in[7:1] == DEV_ADDR) begin
                    busy_d  = 1'b1;
                    state_d = shift_in[0] ? ST_DEV_ACK_R : ST_DEV_ACK_W;
                  end else begin
                    state_d = ST_IGNORE;
                  end
                end
                ST_REG_ADDR: begin
                  ptr_d   = shift_in[DEPTH_LOG2-1:0];
                  state_d = ST_REG_ACK;
                end
                default: begin
                  state_d  = ST_WR_ACK;
                  ack_ok_d = ~wp_on;
                  if (!wp_on) begin
                    mem_we         = 1'b1;
                    wr_strobe_d    = 1'b1;
                    last_wr_data_d = shift_in;
                    ptr_d          = ptr_q + 1'b1;
                  end
                end
              endcase
            end
          end
        end
        ST_DEV_ACK_W, ST_REG_ACK, ST_WR_ACK, ST_DEV_ACK_R: begin
          if (scl_fall) begin
            if (!ack_phase_q) begin
              ack_phase_d = 1'b1;
              sda_low_d   = ack_ok_q;
            end else begin
              ack_phase_d = 1'b0;
              sda_low_d   = 1'b0;
              case (state_q)
                ST_DEV_ACK_W: state_d = ST_REG_ADDR;
                ST_REG_ACK, ST_WR_ACK: state_d = ST_WR_DATA;
                default: begin
                  state_d   = ST_RD_DATA;
                  tx_d      = rd_byte;
                  sda_low_d = ~rd_byte[7];
                  ptr_d     = ptr_q + 1'b1;
                end
              endcase
            end
          end
        end
        ST_RD_DATA: begin
          if (load_pend_q) begin
            if (scl_fall) begin
              load_pend_d = 1'b0;
              tx_d        = rd_byte;
              sda_low_d   = ~rd_byte[7];
              ptr_d       = ptr_q + 1'b1;
            end
          end else if (scl_rise) begin
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) begin
              bit_cnt_d = 4'd0;
              state_d   = ST_RD_ACK;
            end
          end else if (scl_fall) begin
            tx_d      = {tx_q[6:0], 1'b0};
            sda_low_d = ~tx_q[6];
          end
        end
        ST_RD_ACK: begin
          if (scl_fall && !ack_phase_q) begin
            sda_low_d   = 1'b0;
            ack_phase_d = 1'b1;
          end else if (scl_rise && ack_phase_q) begin
            ack_phase_d = 1'b0;
            if (!sda_s2_q) begin
              state_d     = ST_RD_DATA;
              load_pend_d = 1'b1;
            end else begin
              state_d = ST_IGNORE;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs
  always_comb begin
    state_debug  = {4'd0, state_q};
    busy         = busy_q;
    wr_strobe    = wr_strobe_q;
    last_wr_data = last_wr_data_q;
    word_ptr     = 8'(ptr_q);
    dbg_data     = mem_q[dbg_addr[DEPTH_LOG2-1:0]];
  end

  assign sda = sda_low_q ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_i2c_slave_regfile.sv
// Directed bench for i2c_slave_regfile: a bit-banged I2C master drives writes/reads and checks bus and status.
module tb_i2c_slave_regfile;

  localparam int Q = 8;

  logic       clk_12m = 1'b0;
  logic       rst_n;
  logic       scl;
  logic       m_low;
  tri1        sda;
  logic [7:0] dbg_addr;
  logic [7:0] dbg_data;
  logic       wr_strobe;
  logic [7:0] last_wr_data;
  logic [7:0] word_ptr;
  logic [7:0] state_debug;
  logic       busy;
`ifdef I2C_SLAVE_WP_EN
  logic       wp;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int strobe_cnt = 0;

  assign sda = m_low ? 1'b0 : 1'bz;

  i2c_slave_regfile dut (
    .clk_12m     (clk_12m),
    .rst_n       (rst_n),
    .scl         (scl),
    .sda         (sda),
`ifdef I2C_SLAVE_WP_EN
    .wp          (wp),
`endif
    .dbg_addr    (dbg_addr),
    .dbg_data    (dbg_data),
    .wr_strobe   (wr_strobe),
    .last_wr_data(last_wr_data),
    .word_ptr    (word_ptr),
    .state_debug (state_debug),
    .busy        (busy)
  );

  always #5 clk_12m = ~clk_12m;

  always @(negedge clk_12m) if (wr_strobe === 1'b1) strobe_cnt++;

  function automatic logic bus_sda();
    return (sda === 1'b0) ? 1'b0 : 1'b1;
  endfunction

  task automatic wait_q(input int n);
    repeat (n * Q) @(negedge clk_12m);
  endtask

  task automatic i2c_start();
    m_low = 1'b0; wait_q(1);
    scl = 1'b1;   wait_q(1);
    m_low = 1'b1; wait_q(1);
    scl = 1'b0;   wait_q(1);
  endtask

  task automatic i2c_stop();
    m_low = 1'b1; wait_q(1);
    scl = 1'b1;   wait_q(1);
    m_low = 1'b0; wait_q(2);
  endtask

  task automatic wr_bit(input logic b);
    m_low = ~b; wait_q(1);
    scl = 1'b1; wait_q(2);
    scl = 1'b0; wait_q(1);
  endtask

  task automatic rd_bit(output logic b);
    m_low = 1'b0; wait_q(1);
    scl = 1'b1;   wait_q(1);
    b = bus_sda(); wait_q(1);
    scl = 1'b0;   wait_q(1);
  endtask

  task automatic wr_byte(input logic [7:0] v, output logic acked);
    logic b;
    for (int i = 7; i >= 0; i--) wr_bit(v[i]);
    rd_bit(b);
    acked = ~b;
  endtask

  task automatic rd_byte(output logic [7:0] v, input logic master_ack);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      rd_bit(b);
      v[i] = b;
    end
    wr_bit(~master_ack);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; scl = 1'b1; m_low = 1'b0; dbg_addr = 8'h00;
`ifdef I2C_SLAVE_WP_EN
    wp = 1'b0;
`endif
    repeat (4) @(negedge clk_12m);
    n_checks++; if (state_debug !== 8'd0) begin n_fail++; $display("FAIL reset_state got=%0d exp=0", state_debug); end
    n_checks++; if (word_ptr !== 8'h00) begin n_fail++; $display("FAIL reset_word_ptr got=%h exp=00", word_ptr); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_checks++; if (wr_strobe !== 1'b0 || last_wr_data !== 8'h00) begin n_fail++; $display("FAIL reset_wr got=%b/%h exp=0/00", wr_strobe, last_wr_data); end
    n_checks++; if (sda === 1'b0) begin n_fail++; $display("FAIL reset_sda got=%b exp=released", sda); end
    dbg_addr = 8'hFF; #1;
    n_checks++; if (dbg_data !== 8'h00) begin n_fail++; $display("FAIL reset_mem_ff got=%h exp=00", dbg_data); end
    rst_n = 1'b1;
    wait_q(1);
  endtask

  task automatic test_write_read();
    logic a0, a1, a2;
    logic [7:0] d;
    i2c_start();
    wr_byte(8'hA0, a0);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL wr_busy got=%b exp=1", busy); end
    wr_byte(8'h00, a1);
    wr_byte(8'h11, a2);
    n_checks++; if ({a0, a1, a2} !== 3'b111) begin n_fail++; $display("FAIL wr_acks got=%b exp=111", {a0, a1, a2}); end
    i2c_stop();
    n_checks++; if (strobe_cnt !== 1) begin n_fail++; $display("FAIL wr_strobe_cnt got=%0d exp=1", strobe_cnt); end
    n_checks++; if (last_wr_data !== 8'h11) begin n_fail++; $display("FAIL wr_last got=%h exp=11", last_wr_data); end
    n_checks++; if (word_ptr !== 8'h01 || busy !== 1'b0 || state_debug !== 8'd0) begin n_fail++; $display("FAIL wr_after_stop got=%h/%b/%0d exp=01/0/0", word_ptr, busy, state_debug); end
    i2c_start();
    wr_byte(8'hA0, a0);
    wr_byte(8'h00, a1);
    i2c_start();
    wr_byte(8'hA1, a2);
    n_checks++; if ({a0, a1, a2} !== 3'b111) begin n_fail++; $display("FAIL rr_acks got=%b exp=111", {a0, a1, a2}); end
    rd_byte(d, 1'b0);
    n_checks++; if (d !== 8'h11) begin n_fail++; $display("FAIL rr_data got=%h exp=11", d); end
    n_checks++; if (state_debug !== 8'd10) begin n_fail++; $display("FAIL rr_nack_state got=%0d exp=10", state_debug); end
    i2c_stop();
    dbg_addr = 8'h00; #1;
    n_checks++; if (dbg_data !== 8'h11 || word_ptr !== 8'h01) begin n_fail++; $display("FAIL rr_dbg got=%h/%h exp=11/01", dbg_data, word_ptr); end
  endtask

  task automatic test_wrong_addr();
    logic a;
    i2c_start();
    wr_byte(8'hA2, a);
    n_checks++; if (a !== 1'b0) begin n_fail++; $display("FAIL wa_ack got=%b exp=0", a); end
    n_checks++; if (state_debug !== 8'd10) begin n_fail++; $display("FAIL wa_state got=%0d exp=10", state_debug); end
    i2c_stop();
    dbg_addr = 8'h00; #1;
    n_checks++; if (busy !== 1'b0 || dbg_data !== 8'h11 || strobe_cnt !== 1) begin n_fail++; $display("FAIL wa_after got=%b/%h/%0d exp=0/11/1", busy, dbg_data, strobe_cnt); end
  endtask

  task automatic test_page_write_wrap();
    logic a0, a1, a2, a3, a4;
    i2c_start();
    wr_byte(8'hA0, a0);
    wr_byte(8'hFE, a1);
    wr_byte(8'hAA, a2);
    wr_byte(8'hBB, a3);
    wr_byte(8'hCC, a4);
    i2c_stop();
    n_checks++; if ({a0, a1, a2, a3, a4} !== 5'b11111) begin n_fail++; $display("FAIL pw_acks got=%b exp=11111", {a0, a1, a2, a3, a4}); end
    dbg_addr = 8'hFE; #1;
    n_checks++; if (dbg_data !== 8'hAA) begin n_fail++; $display("FAIL pw_fe got=%h exp=aa", dbg_data); end
    dbg_addr = 8'hFF; #1;
    n_checks++; if (dbg_data !== 8'hBB) begin n_fail++; $display("FAIL pw_ff got=%h exp=bb", dbg_data); end
    dbg_addr = 8'h00; #1;
    n_checks++; if (dbg_data !== 8'hCC) begin n_fail++; $display("FAIL pw_00 got=%h exp=cc", dbg_data); end
    n_checks++; if (word_ptr !== 8'h01 || strobe_cnt !== 4 || last_wr_data !== 8'hCC) begin n_fail++; $display("FAIL pw_status got=%h/%0d/%h exp=01/4/cc", word_ptr, strobe_cnt, last_wr_data); end
  endtask

  task automatic test_seq_read();
    logic a0, a1, a2;
    logic [7:0] d0, d1, d2;
    i2c_start();
    wr_byte(8'hA0, a0);
    wr_byte(8'hFE, a1);
    i2c_start();
    wr_byte(8'hA1, a2);
    rd_byte(d0, 1'b1);
    rd_byte(d1, 1'b1);
    rd_byte(d2, 1'b0);
    i2c_stop();
    n_checks++; if ({a0, a1, a2} !== 3'b111) begin n_fail++; $display("FAIL sr_acks got=%b exp=111", {a0, a1, a2}); end
    n_checks++; if ({d0, d1, d2} !== 24'hAABBCC) begin n_fail++; $display("FAIL sr_data got=%h exp=aabbcc", {d0, d1, d2}); end
    n_checks++; if (word_ptr !== 8'h01) begin n_fail++; $display("FAIL sr_ptr got=%h exp=01", word_ptr); end
  endtask

  task automatic test_current_read();
    logic a;
    logic [7:0] d0, d1;
    i2c_start();
    wr_byte(8'hA0, a);
    wr_byte(8'h20, a);
    wr_byte(8'h3C, a);
    wr_byte(8'h4D, a);
    i2c_stop();
    n_checks++; if (word_ptr !== 8'h22 || strobe_cnt !== 6) begin n_fail++; $display("FAIL cr_write got=%h/%0d exp=22/6", word_ptr, strobe_cnt); end
    i2c_start();
    wr_byte(8'hA0, a);
    wr_byte(8'h20, a);
    i2c_stop();
    n_checks++; if (word_ptr !== 8'h20) begin n_fail++; $display("FAIL cr_setptr got=%h exp=20", word_ptr); end
    i2c_start();
    wr_byte(8'hA1, a);
    rd_byte(d0, 1'b1);
    rd_byte(d1, 1'b0);
    i2c_stop();
    n_checks++; if ({d0, d1} !== 16'h3C4D || word_ptr !== 8'h22) begin n_fail++; $display("FAIL cr_data got=%h/%h exp=3c4d/22", {d0, d1}, word_ptr); end
  endtask

  task automatic test_partial_stop();
    logic a;
    i2c_start();
    wr_byte(8'hA0, a);
    wr_byte(8'h30, a);
    for (int i = 0; i < 4; i++) wr_bit(1'b1);
    i2c_stop();
    dbg_addr = 8'h30; #1;
    n_checks++; if (strobe_cnt !== 6 || dbg_data !== 8'h00) begin n_fail++; $display("FAIL ps_nocommit got=%0d/%h exp=6/00", strobe_cnt, dbg_data); end
    n_checks++; if (state_debug !== 8'd0 || busy !== 1'b0 || word_ptr !== 8'h30) begin n_fail++; $display("FAIL ps_status got=%0d/%b/%h exp=0/0/30", state_debug, busy, word_ptr); end
  endtask

  task automatic test_reset_mid();
    logic a;
    i2c_start();
    wr_byte(8'hA1, a);
    n_checks++; if (sda !== 1'b0) begin n_fail++; $display("FAIL rm_driving got=%b exp=0", sda); end
    rst_n = 1'b0; #1;
    n_checks++; if (sda === 1'b0 || state_debug !== 8'd0 || word_ptr !== 8'h00) begin n_fail++; $display("FAIL rm_reset got=%b/%0d/%h exp=released/0/00", sda, state_debug, word_ptr); end
    dbg_addr = 8'hFE; #1;
    n_checks++; if (dbg_data !== 8'h00) begin n_fail++; $display("FAIL rm_mem got=%h exp=00", dbg_data); end
    wait_q(1);
    rst_n = 1'b1;
    m_low = 1'b0;
    wait_q(1);
    scl = 1'b1;
    wait_q(2);
  endtask

`ifdef I2C_SLAVE_WP_EN
  task automatic test_write_protect();
    logic a0, a1, a2;
    int s0;
    s0 = strobe_cnt;
    wp = 1'b1;
    wait_q(1);
    i2c_start();
    wr_byte(8'hA0, a0);
    wr_byte(8'h10, a1);
    wr_byte(8'h55, a2);
    i2c_stop();
    wp = 1'b0;
    n_checks++; if ({a0, a1, a2} !== 3'b110) begin n_fail++; $display("FAIL wp_acks got=%b exp=110", {a0, a1, a2}); end
    dbg_addr = 8'h10; #1;
    n_checks++; if (dbg_data !== 8'h00 || strobe_cnt !== s0 || word_ptr !== 8'h10) begin n_fail++; $display("FAIL wp_nocommit got=%h/%0d/%h exp=00/%0d/10", dbg_data, strobe_cnt, word_ptr, s0); end
  endtask
`endif

  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_write_read();
    test_wrong_addr();
    test_page_write_wrap();
    test_seq_read();
    test_current_read();
    test_partial_stop();
    test_reset_mid();
`ifdef I2C_SLAVE_WP_EN
    test_write_protect();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
